// File: rtl/irrigation_zones.sv
// irrigation_zones: debounced tank/climate sensing, inlet valve, alarm and round-robin zone watering (in: clk rst_n H M L Ua T Us zone_en; out: Ve Al E Bs Vs busy)
module irrigation_zones #(
  parameter int N_ZONES       = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int WATER_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               H,
  input  logic               M,
  input  logic               L,
  input  logic               Ua,
  input  logic               T,
  input  logic [N_ZONES-1:0] Us,
  input  logic [N_ZONES-1:0] zone_en,
  output logic               Ve,
  output logic               Al,
  output logic               E,
  output logic [N_ZONES-1:0] Bs,
  output logic [N_ZONES-1:0] Vs,
  output logic               busy
);
  localparam int NI = N_ZONES + 5;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2((WATER_CYCLES > SETTLE_CYCLES ? WATER_CYCLES : SETTLE_CYCLES) + 1);
  localparam int ZW = N_ZONES > 1 ? $clog2(N_ZONES) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, WATER, SETTLE} state_t;

  logic [NI-1:0] sync1_q, sync2_q, deb_q, deb_d;
  logic [NI-1:0][DW-1:0] dcnt_q, dcnt_d;
  logic h, m, l, ua, t;
  logic [N_ZONES-1:0] us, req;
  logic e_d, e_q, al_d, al_q, ve_d, ve_q;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ZW-1:0] grant_q, grant_d, last_q, last_d, sel, idx;
  logic found, drip_q, drip_d, busy_q, busy_d;
  logic [N_ZONES-1:0] bs_q, bs_d, vs_q, vs_d, onehot;

  assign {us, t, ua, l, m, h} = deb_q;
  assign req = zone_en & ~us;
  assign e_d = (m & ~l) | (h & ~m);
  assign al_d = e_d | ~l;
  assign ve_d = (h | e_d) ? 1'b0 : (~m | ve_q);

  always_comb begin
    deb_d = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < NI; i++)
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
  end

  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = N_ZONES - 1; k >= 0; k--) begin
      idx = ZW'((int'(last_q) + 1 + k) % N_ZONES);
      if (req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    last_d = last_q;
    drip_d = drip_q;
    case (state_q)
      IDLE: if (|req && !al_d) state_d = SELECT;
      SELECT: begin
        state_d = found ? WATER : IDLE;
        cnt_d = '0;
        if (found) begin
          grant_d = sel;
          last_d = sel;
          drip_d = (t & ~ua) | ~m;
        end
      end
      WATER: begin
        if (cnt_q == CW'(WATER_CYCLES - 1) || us[grant_q] || !zone_en[grant_q] || al_d) begin
          state_d = SETTLE;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
    endcase
    onehot = N_ZONES'(1) << grant_d;
    bs_d = (state_d == WATER && !drip_d) ? onehot : '0;
    vs_d = (state_d == WATER && drip_d) ? onehot : '0;
    busy_d = state_d == SELECT || state_d == WATER;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q <= '0;
      dcnt_q <= '0;
      e_q <= 1'b0;
      al_q <= 1'b0;
      ve_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= '0;
      last_q <= ZW'(N_ZONES - 1);
      drip_q <= 1'b0;
      bs_q <= '0;
      vs_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sync1_q <= {Us, T, Ua, L, M, H};
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      dcnt_q <= dcnt_d;
      e_q <= e_d;
      al_q <= al_d;
      ve_q <= ve_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      last_q <= last_d;
      drip_q <= drip_d;
      bs_q <= bs_d;
      vs_q <= vs_d;
      busy_q <= busy_d;
    end

  assign E = e_q;
  assign Al = al_q;
  assign Ve = ve_q;
  assign Bs = bs_q;
  assign Vs = vs_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_irrigation_zones.sv
// tb_irrigation_zones: scoreboard bench for irrigation_zones (N_ZONES=4, DEB=4, WATER=16, SETTLE=2)
module tb_irrigation_zones;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic H = 1'b0, M = 1'b0, L = 1'b0, Ua = 1'b0, T = 1'b0;
  logic [3:0] Us = 4'hF, zone_en = 4'h0;
  logic Ve, Al, E, busy;
  logic [3:0] Bs, Vs;
  int n_chk = 0, n_err = 0;

  typedef struct {
    logic [3:0] bs;
    logic [3:0] vs;
    int len;
  } grant_t;
  grant_t sb[$];

  irrigation_zones #(
    .N_ZONES(4), .DEB_CYCLES(4), .WATER_CYCLES(16), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .H(H), .M(M), .L(L), .Ua(Ua), .T(T),
    .Us(Us), .zone_en(zone_en), .Ve(Ve), .Al(Al), .E(E),
    .Bs(Bs), .Vs(Vs), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_active(input int budget, input string tag);
    int n = 0;
    while ((Bs | Vs) == 4'h0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'((Bs | Vs) != 4'h0), 1);
  endtask

  task automatic wait_sb(input int budget, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  bit active = 1'b0;
  logic [3:0] cur_bs, cur_vs;
  int cur_len;
  grant_t g;

  initial forever begin
    @(negedge clk);
    if (!rst_n) active = 1'b0;
    else if ((Bs | Vs) != 4'h0) begin
      if (!active) begin
        active = 1'b1;
        cur_bs = Bs;
        cur_vs = Vs;
        cur_len = 0;
        chk("onehot", $countones(Bs | Vs), 1);
        chk("bs_vs_excl", Bs & Vs, 0);
      end
      cur_len++;
    end else if (active) begin
      active = 1'b0;
      chk("sb_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        g = sb.pop_front();
        chk("grant_bs", cur_bs, g.bs);
        chk("grant_vs", cur_vs, g.vs);
        chk("grant_len", cur_len, g.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tick(2);
    chk("reset_outputs", {Ve, Al, E, busy, Bs, Vs}, 0);
    rst_n = 1'b1;
    tick(1);
    chk("al_after_reset", Al, 1);
    chk("ve_after_reset", Ve, 1);
    L = 1'b1; tick(3); L = 1'b0; tick(8);
    chk("glitch_al", Al, 1);
    L = 1'b1; tick(6);
    chk("deb_edge6_al", Al, 1);
    tick(1);
    chk("deb_edge7_al", Al, 0);
    chk("ve_low_only", Ve, 1);
    chk("e_low_only", E, 0);
    M = 1'b1; tick(10);
    chk("ve_mid_hold", Ve, 1);
    H = 1'b1; tick(10);
    chk("ve_high_clear", Ve, 0);
    M = 1'b0; tick(10);
    chk("err_e", E, 1);
    chk("err_al", Al, 1);
    chk("err_ve", Ve, 0);
    M = 1'b1; tick(10);
    chk("err_clear_e", E, 0);
    chk("err_clear_al", Al, 0);
    H = 1'b0; tick(10);
    chk("ve_mid_stay_off", Ve, 0);
    H = 1'b1; tick(10);

    Ua = 1'b1; T = 1'b0; Us = 4'b1011; tick(10);
    sb.push_back(grant_t'{4'b0100, 4'b0000, 16});
    zone_en = 4'hF;
    wait_active(10, "start_full");
    chk("busy_water", busy, 1);
    n = 0;
    while ((Bs | Vs) != 4'h0 && n < 40) begin tick(1); n++; end
    chk("full_end", Bs | Vs, 0);
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("settle_gap", n, 3);
    sb.push_back(grant_t'{4'b0100, 4'b0000, 5});
    wait_active(5, "start_repeat");
    tick(4);
    zone_en = 4'h0;
    wait_sb(20, "sb_full");

    Us = 4'b0111; T = 1'b1; Ua = 1'b0; tick(10);
    sb.push_back(grant_t'{4'b0000, 4'b1000, 16});
    sb.push_back(grant_t'{4'b0000, 4'b0001, 16});
    zone_en = 4'hF;
    wait_active(10, "start_z3");
    Us = 4'b0110;
    wait_sb(60, "sb_rr");
    wait_active(10, "start_z3_again");
    sb.push_back(grant_t'{4'b0000, 4'b1000, 7});
    Us = 4'hF;
    wait_sb(20, "sb_rr2");

    zone_en = 4'h0; Ua = 1'b1; T = 1'b0; Us = 4'b1110; tick(10);
    sb.push_back(grant_t'{4'b0001, 4'b0000, 7});
    zone_en = 4'hF;
    wait_active(10, "start_abort");
    H = 1'b0; M = 1'b0; L = 1'b0;
    n = 0;
    while (!Al && n < 20) begin tick(1); n++; end
    chk("abort_al", Al, 1);
    chk("abort_outputs_same_cycle", Bs | Vs, 0);
    chk("abort_busy", busy, 0);
    tick(30);
    chk("no_grant_under_alarm", busy, 0);
    chk("sb_abort", sb.size(), 0);
    chk("ve_refill", Ve, 1);

    zone_en = 4'h0; H = 1'b1; M = 1'b1; L = 1'b1; Us = 4'b1010; tick(12);
    chk("al_restored", Al, 0);
    zone_en = 4'hF;
    wait_active(10, "start_rst");
    chk("rr_after_zone0", Bs, 4'b0100);
    tick(7);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_water", {Ve, Al, E, busy, Bs, Vs}, 0);
    tick(2);
    sb.push_back(grant_t'{4'b0001, 4'b0000, 16});
    rst_n = 1'b1;
    wait_active(20, "start_after_reset");
    wait_sb(30, "sb_rst");
    zone_en = 4'h0;
    tick(10);
    chk("idle_end", busy, 0);
    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/irrigation_zones.md
IRRIGATION_ZONES -- requirements
Module: irrigation_zones

Interface
REQ-001 Parameter N_ZONES, default 4, number of irrigation zones (range 1..16).
REQ-002 Parameter DEB_CYCLES, default 4, consecutive equal samples required to accept a sensor change (range 1..255).
REQ-003 Parameter WATER_CYCLES, default 16, maximum irrigation duration per grant, in clocks (range 1..65535).
REQ-004 Parameter SETTLE_CYCLES, default 2, dead time after each grant, in clocks (range 1..255).
REQ-005 Port: clk, input, 1, single clock; all state on rising edge.
REQ-006 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Ports: H, M, L, inputs, 1 each, tank level sensors for high, mid and low; 1 = water present at that level.
REQ-008 Port: Ua, input, 1, air humidity high.
REQ-009 Port: T, input, 1, temperature high.
REQ-010 Port: Us, input, N_ZONES, soil wet, per zone.
REQ-011 Port: zone_en, input, N_ZONES, zone enable mask; read directly, no debounce.
REQ-012 Ports: Ve, Al, E, outputs, 1 each; inlet valve, alarm, sensor error.
REQ-013 Ports: Bs, Vs, outputs, N_ZONES each; sprinkler pump and drip valve, per zone.
REQ-014 Port: busy, output, 1, a zone grant is in progress (SELECT or WATER state).

Function
REQ-015 Every input except zone_en shall pass through a 2-flop synchroniser and then a debouncer; all logic shall use only the debounced values (suffix _d below).
REQ-016 A debounced value shall change on the edge where the synchronised value has differed from it for DEB_CYCLES consecutive edges; any intermediate mismatch restarts the count.
REQ-017 E shall be registered and equal (M_d & ~L_d) | (H_d & ~M_d).
REQ-018 Al shall be registered and equal E | ~L_d.
REQ-019 Ve shall be a hysteresis flop:
- set when ~M_d & ~E
- cleared when H_d | E
- clear has priority.
REQ-020 The scheduler FSM shall have four states: IDLE, SELECT, WATER, SETTLE.
REQ-021 Zone i is requesting when zone_en[i] & ~Us_d[i].
REQ-022 IDLE -> SELECT when any zone is requesting and ~Al; otherwise the FSM stays in IDLE.
REQ-023 In SELECT (one cycle), the scheduler shall grant the requesting zone found first in round-robin order, starting at last_served+1 modulo N_ZONES.
REQ-024 In SELECT, the scheduler shall latch the mode:
- DRIP if T_d & ~Ua_d, or if ~M_d
- otherwise SPRAY.
REQ-025 In SELECT, the scheduler shall update last_served and go to WATER.
REQ-026 If no zone is still requesting in SELECT, it shall go to IDLE with no grant.
REQ-027 In WATER, only the granted zone's output shall be 1: Bs[g] in SPRAY mode, Vs[g] in DRIP mode. All other Bs/Vs bits shall be 0.
REQ-028 In WATER, a cycle counter shall start at 0 on entry. The FSM shall go to SETTLE when any of the following holds:
- counter reaches WATER_CYCLES-1
- Us_d[g]
- ~zone_en[g]
- Al.
REQ-029 Outputs shall drop in the same cycle SETTLE is entered; an early exit when Al rises has no extra delay.
REQ-030 SETTLE shall hold all Bs/Vs at 0 for SETTLE_CYCLES clocks, then go to IDLE.
REQ-031 Bs and Vs shall never both be 1, and at most one bit of Bs|Vs shall be 1, in any cycle.
REQ-032 Bs, Vs and busy shall be registered (Moore) outputs.
REQ-033 Counter widths shall be derived with $clog2 of the parameter; counters shall not wrap.

Reset
REQ-034 With rst_n=0:
- all outputs shall be 0
- FSM in IDLE
- last_served = N_ZONES-1, so zone 0 is first
- debounced values = 0.
REQ-035 Reset mid-WATER shall de-assert Bs/Vs asynchronously, with no SETTLE.
REQ-036 Debounced level values reset to 0, so Al=1 immediately after reset until L_d settles to 1.

Verification (N_ZONES=4, DEB=4, WATER=16, SETTLE=2)
REQ-037 Debounce: L glitches to 1 for 3 clocks -> L_d stays 0 and Al stays 1. L held at 1 -> L_d=1 at the 6th edge after the change is sampled, and Al=0 one edge later.
REQ-038 Full watering:
- stimulus: H=M=L=1, Ua=1, T=0, Us=4'b1011, zone_en=4'hF
- zone 2 granted with SPRAY mode
- Bs=4'b0100 for exactly 16 clocks
- then 2 clocks of all-zero outputs, then IDLE.
REQ-039 Round-robin and mode:
- stimulus: zones 0 and 3 dry, zone 3 served last, T=1, Ua=0
- zone 0 granted next with DRIP mode (Vs=4'b0001)
- on the following grant, zone 3 is granted.
REQ-040 Early abort: during WATER, L drops to 0 -> when Al rises, Bs/Vs=0 in that same cycle; SETTLE, then IDLE; no new grant while Al=1.
REQ-041 Error and inlet valve:
- level falls to L only -> Ve=1
- rises to H -> Ve=0
- H=1, M=0, L=1 (inconsistent) -> E=1, Al=1, Ve=0.
REQ-042 Reset mid-WATER at count 7 -> all outputs 0 asynchronously. After release, the first grant goes to the lowest-index dry zone.
